fft_r2_engine: RTL and testbench

- Parametrised in-place radix-2 DIT FFT/IFFT engine; successor to the fixed 64-point, 11-bit `myFFT` core.
- Transform size, sample width and twiddle width are parameters.
- Forward/inverse mode is selected at `start`.
- Input and output are valid/ready sample streams, replacing the flat 64-word input bus; twiddles come from an external ROM port.

---
 rtl/fft_r2_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_fft_r2_engine.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_r2_engine.sv
// fft_r2_engine: in-place radix-2 DIT FFT/IFFT with streamed load and unload.
// Define FFT_SCALE_EN for a 1/2 scale per stage; otherwise results saturate.
module fft_r2_engine #(
    parameter int LOG2N = 6,
    parameter int DW    = 11,
    parameter int TW    = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   inv,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DW-1:0]   in_re,
    input  logic signed [DW-1:0]   in_im,
    output logic [LOG2N-2:0]       tw_addr,
    input  logic signed [TW-1:0]   tw_re,
    input  logic signed [TW-1:0]   tw_im,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [DW-1:0]   out_re,
    output logic signed [DW-1:0]   out_im,
    output logic [LOG2N-1:0]       out_index,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    localparam int N    = 1 << LOG2N;
    localparam int SW   = DW + 4;
    localparam int PW   = DW + TW + 2;
    localparam int IMAX = (1 << (DW - 1)) - 1;

    localparam logic signed [SW-1:0] SMAX  = SW'(IMAX);
    localparam logic signed [SW-1:0] SMIN  = SW'(-IMAX - 1);
    localparam logic signed [PW-1:0] RND   = PW'(1 << (TW - 2));
    localparam logic [LOG2N-1:0]     ONE_N = LOG2N'(1);
    localparam logic [LOG2N-2:0]     ONE_B = (LOG2N - 1)'(1);
    localparam logic [3:0]           LAST_S = 4'(LOG2N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_UNLOAD
    } state_e;

    state_e            state_q, state_d;
    logic              inv_q, inv_d;
    logic              done_q, done_d;
    logic [LOG2N-1:0]  cnt_q, cnt_d;
    logic [3:0]        stg_q, stg_d;
    logic [LOG2N-2:0]  bfly_q, bfly_d;

    logic signed [DW-1:0] mem_re_q [N];
    logic signed [DW-1:0] mem_im_q [N];

    logic              ld_we, bf_we;
    logic [LOG2N-1:0]  ld_addr;
    logic [LOG2N-1:0]  b_ext, half, j_idx, p_idx, q_idx;
    logic [3:0]        tw_sh;
    logic [LOG2N-2:0]  tw_k;

    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
    logic signed [DW-1:0] y0_re, y0_im, y1_re, y1_im;
    logic signed [PW-1:0] bx_re, bx_im, wx_re, wx_im;
    logic signed [SW-1:0] t_re, t_im;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        for (int i = 0; i < LOG2N; i++) begin
            bitrev[i] = v[LOG2N-1-i];
        end
    endfunction

    function automatic logic signed [DW-1:0] narrow(
        input logic signed [SW-1:0] v
    );
        logic signed [SW-1:0] s;
`ifdef FFT_SCALE_EN
        s = (v + SW'(1)) >>> 1;
`else
        s = v;
`endif
        if (s > SMAX) begin
            narrow = SMAX[DW-1:0];
        end else if (s < SMIN) begin
            narrow = SMIN[DW-1:0];
        end else begin
            narrow = s[DW-1:0];
        end
    endfunction

    assign ld_addr = bitrev(cnt_q);

    always_comb begin
        b_ext = {1'b0, bfly_q};
        half  = ONE_N << stg_q;
        j_idx = b_ext & (half - ONE_N);
        p_idx = ((b_ext >> stg_q) << (stg_q + 4'd1)) | j_idx;
        q_idx = p_idx | half;
        tw_sh = LAST_S - stg_q;
        tw_k  = j_idx[LOG2N-2:0] << tw_sh;
    end

    always_comb begin
        a_re  = mem_re_q[p_idx];
        a_im  = mem_im_q[p_idx];
        b_re  = mem_re_q[q_idx];
        b_im  = mem_im_q[q_idx];
        bx_re = PW'(b_re);
        bx_im = PW'(b_im);
        wx_re = PW'(tw_re);
        wx_im = inv_q ? -PW'(tw_im) : PW'(tw_im);
        // Index 0 is exactly 1+0j, which a TW-bit cosine cannot represent.
        if (j_idx == '0) begin
            t_re = SW'(b_re);
            t_im = SW'(b_im);
        end else begin
            t_re = SW'((bx_re * wx_re - bx_im * wx_im + RND) >>> (TW - 1));
            t_im = SW'((bx_re * wx_im + bx_im * wx_re + RND) >>> (TW - 1));
        end
        y0_re = narrow(SW'(a_re) + t_re);
        y0_im = narrow(SW'(a_im) + t_im);
        y1_re = narrow(SW'(a_re) - t_re);
        y1_im = narrow(SW'(a_im) - t_im);
    end

    always_comb begin
        state_d = state_q;
        inv_d   = inv_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
        bfly_d  = bfly_q;
        done_d  = 1'b0;
        ld_we   = 1'b0;
        bf_we   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    inv_d   = inv;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    ld_we = 1'b1;
                    cnt_d = cnt_q + ONE_N;
                    if (&cnt_q) begin
                        state_d = S_CALC;
                        stg_d   = '0;
                        bfly_d  = '0;
                    end
                end
            end
            S_CALC: begin
                bf_we  = 1'b1;
                bfly_d = bfly_q + ONE_B;
                if (&bfly_q) begin
                    if (stg_q == LAST_S) begin
                        state_d = S_UNLOAD;
                        cnt_d   = '0;
                    end else begin
                        stg_d = stg_q + 4'd1;
                    end
                end
            end
            S_UNLOAD: begin
                if (out_ready) begin
                    cnt_d = cnt_q + ONE_N;
                    if (&cnt_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            inv_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            stg_q   <= '0;
            bfly_q  <= '0;
        end else begin
            state_q <= state_d;
            inv_q   <= inv_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
            bfly_q  <= bfly_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem_re_q[ld_addr] <= in_re;
            mem_im_q[ld_addr] <= in_im;
        end
        if (bf_we) begin
            mem_re_q[p_idx] <= y0_re;
            mem_im_q[p_idx] <= y0_im;
            mem_re_q[q_idx] <= y1_re;
            mem_im_q[q_idx] <= y1_im;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_UNLOAD);
    assign out_index = out_valid ? cnt_q : '0;
    assign out_last  = out_valid && (&cnt_q);
    assign out_re    = out_valid ? mem_re_q[cnt_q] : '0;
    assign out_im    = out_valid ? mem_im_q[cnt_q] : '0;
    assign tw_addr   = (state_q == S_CALC) ? tw_k : '0;
    assign done      = done_q;

endmodule

// File: tb/tb_fft_r2_engine.sv
// tb_fft_r2_engine: directed FFT runs with a bin scoreboard and a twiddle ROM.
// Expected bins follow the FFT_SCALE_EN setting of the build.
module tb_fft_r2_engine;

    localparam int LOG2N = 6;
    localparam int N     = 64;
    localparam int DW    = 11;
    localparam int TW    = 11;

`ifdef FFT_SCALE_EN
    localparam int DIV   = 64;
    localparam int COS_X = 128;
    localparam int COS_T = 3;
`else
    localparam int DIV   = 1;
    localparam int COS_X = 1023;
    localparam int COS_T = 1;
`endif

    typedef struct {
        int idx;
        int re;
        int im;
        int tol;
        bit ckre;
        bit ckim;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 inv = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_re = '0;
    logic signed [DW-1:0] in_im = '0;
    logic [LOG2N-2:0]     tw_addr;
    logic signed [TW-1:0] tw_re, tw_im;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] out_re, out_im;
    logic [LOG2N-1:0]     out_index;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    logic signed [TW-1:0] rom_re [N/2];
    logic signed [TW-1:0] rom_im [N/2];
    int x_re [N];
    int x_im [N];
    exp_t sb [$];
    int total = 0;
    int passed = 0;
    int failed = 0;
    int done_cnt = 0;

    fft_r2_engine #(.LOG2N(LOG2N), .DW(DW), .TW(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .inv       (inv),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .tw_addr   (tw_addr),
        .tw_re     (tw_re),
        .tw_im     (tw_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    assign tw_re = rom_re[tw_addr];
    assign tw_im = rom_im[tw_addr];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

    function automatic int clip(input int v);
        if (v > 1023) return 1023;
        if (v < -1024) return -1024;
        return v;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv,
                       input int tol);
        int d;
        d = obs - expv;
        if (d < 0) d = -d;
        total++;
        assert (d <= tol) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic void push_bin(input int idx, input int re, input int im,
                                     input int tol, input bit ckre,
                                     input bit ckim);
        sb.push_back('{idx: idx, re: re, im: im, tol: tol,
                       ckre: ckre, ckim: ckim});
    endfunction

    function automatic void zero_x();
        for (int n = 0; n < N; n++) begin
            x_re[n] = 0;
            x_im[n] = 0;
        end
    endfunction

    task automatic run_load(input bit inv_i, input bit gaps);
        int n;
        int guard;
        bit hs;
        in_valid = 1'b1;
        in_re = DW'(300);
        in_im = -DW'(5);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        inv = inv_i;
        @(posedge clk);
        #1;
        start = 1'b0;
        inv = 1'b0;
        chk("load_in_ready", in_ready, 1, 0);
        n = 0;
        guard = 0;
        while (n < N && guard < 8 * N) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_re = DW'(x_re[n]);
            in_im = DW'(x_im[n]);
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs) n++;
            guard++;
        end
        in_valid = 1'b0;
        chk("load_count", n, N, 0);
    endtask

    task automatic calc_time(input bit poke, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 1000) begin
            start = poke && (cyc == 20);
            inv = start;
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        inv = 1'b0;
    endtask

    task automatic drain(input bit rand_ready, input int hold);
        int guard;
        int d0;
        bit fin;
        exp_t e;
        fin = 1'b0;
        guard = 0;
        d0 = done_cnt;
        while (!fin && guard < 3000) begin
            if (guard < hold) out_ready = 1'b0;
            else out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) begin
                chk("sb_has_entry", int'(sb.size() > 0), 1, 0);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk($sformatf("bin%0d_index", e.idx), out_index, e.idx, 0);
                    chk($sformatf("bin%0d_last", e.idx), out_last,
                        int'(e.idx == N - 1), 0);
                    if (e.ckre)
                        chk($sformatf("bin%0d_re", e.idx), out_re, e.re, e.tol);
                    if (e.ckim)
                        chk($sformatf("bin%0d_im", e.idx), out_im, e.im, e.tol);
                end
                fin = out_last;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        out_ready = 1'b0;
        chk("drain_finished", fin, 1, 0);
        chk("sb_empty", sb.size(), 0, 0);
        chk("done_high", done, 1, 0);
        chk("idle_after", busy, 0, 0);
        @(posedge clk);
        #1;
        chk("done_low", done, 0, 0);
        chk("done_pulses", done_cnt - d0, 1, 0);
    endtask

    initial begin
        int cyc;
        int d0;
        for (int k = 0; k < N / 2; k++) begin
            real a;
            a = 2.0 * 3.14159265358979 * k / N;
            rom_re[k] = TW'(clip(rnd(1024.0 * $cos(a))));
            rom_im[k] = TW'(clip(rnd(-1024.0 * $sin(a))));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0, 0);
        chk("rst_done", done, 0, 0);
        chk("rst_in_ready", in_ready, 0, 0);
        chk("rst_out_valid", out_valid, 0, 0);
        chk("rst_out_last", out_last, 0, 0);
        chk("rst_out_index", out_index, 0, 0);
        chk("rst_out_re", out_re, 0, 0);
        chk("rst_tw_addr", tw_addr, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        zero_x();
        x_re[0] = 512;
        for (int k = 0; k < N; k++) push_bin(k, 512 / DIV, 0, 1, 1, 1);
        run_load(1'b0, 1'b0);
        chk("calc_in_ready", in_ready, 0, 0);
        chk("calc_busy", busy, 1, 0);
        calc_time(1'b0, cyc);
        chk("impulse_calc_cycles", cyc, 192, 0);
        drain(1'b0, 0);

        for (int n = 0; n < N; n++) x_re[n] = 8;
        for (int k = 0; k < N; k++)
            push_bin(k, (k == 0) ? 512 / DIV : 0, 0, 1, 1, 1);
        run_load(1'b0, 1'b1);
        calc_time(1'b1, cyc);
        chk("dc_calc_cycles", cyc, 192, 0);
        drain(1'b0, 0);

        for (int n = 0; n < N; n++) x_re[n] = 1023;
        for (int k = 0; k < N; k++)
            push_bin(k, (k == 0) ? 1023 : 0, 0, 1, 1, 1);
        run_load(1'b0, 1'b0);
        calc_time(1'b0, cyc);
        drain(1'b0, 0);

        for (int n = 0; n < N; n++)
            x_re[n] = rnd(256.0 * $cos(2.0 * 3.14159265358979 * n / N));
        for (int k = 0; k < N; k++)
            push_bin(k, COS_X, 0, COS_T, (k == 1) || (k == 63), 1'b0);
        run_load(1'b1, 1'b0);
        calc_time(1'b0, cyc);
        drain(1'b1, 40);

        zero_x();
        x_re[1] = 256;
        for (int k = 0; k < N; k++) begin
            if (k == 16) push_bin(k, 0, -256 / DIV, 1, 1, 1);
            else if (k == 48) push_bin(k, 0, 256 / DIV, 1, 1, 1);
            else push_bin(k, 256 / DIV, 0, 1, k == 0, k == 0);
        end
        run_load(1'b0, 1'b0);
        calc_time(1'b0, cyc);
        drain(1'b1, 0);

        for (int k = 0; k < N; k++) begin
            if (k == 16) push_bin(k, 0, 256 / DIV, 1, 1, 1);
            else if (k == 48) push_bin(k, 0, -256 / DIV, 1, 1, 1);
            else push_bin(k, 256 / DIV, 0, 1, k == 0, k == 0);
        end
        run_load(1'b1, 1'b0);
        calc_time(1'b0, cyc);
        drain(1'b0, 0);

        zero_x();
        x_re[0] = 512;
        run_load(1'b0, 1'b0);
        repeat (50) @(posedge clk);
        #2;
        d0 = done_cnt;
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0, 0);
        chk("abort_in_ready", in_ready, 0, 0);
        chk("abort_out_valid", out_valid, 0, 0);
        chk("abort_tw_addr", tw_addr, 0, 0);
        chk("abort_out_re", out_re, 0, 0);
        chk("abort_done", done, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("abort_no_done", done_cnt - d0, 0, 0);
        @(posedge clk);
        #1;

        for (int k = 0; k < N; k++) push_bin(k, 512 / DIV, 0, 1, 1, 1);
        run_load(1'b0, 1'b0);
        calc_time(1'b0, cyc);
        chk("rerun_calc_cycles", cyc, 192, 0);
        drain(1'b1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
